// File: rtl/hex_row_renderer.sv
// hex_row_renderer
//   Reader side of the 5x5 hex-digit character generator. A start latches an
//   NDIGITS-wide hex value. The block then walks rows 0..4, and within each row
//   the digits from MSB to LSB. For every digit it addresses the glyph ROM and
//   serialises the returned 5-bit row LSB-first as a valid/ready pixel stream.
//   GAP blank columns separate adjacent digits. One start produces one 5-row
//   frame.
//
//   Optional feature macro: HEX_RENDER_LEADING_BLANK_EN
//     When defined, the leading zero nibbles (counted from the MSB) are flagged
//     at start, and those digits emit all-0 pixels. Digit 0 is never blanked.
//     Timing, pixel count and flags are unchanged.
//
// Ports
//   clk            in   1          system clock
//   rst_n          in   1          asynchronous active-low reset
//   start          in   1          begin a frame (honoured only when busy=0)
//   value          in   4*NDIGITS  hex value, digit NDIGITS-1 leftmost
//   busy           out  1          frame in progress
//   rom_digit      out  4          glyph ROM digit address
//   rom_yoff       out  3          glyph ROM row address (0..4)
//   rom_bits       in   5          glyph ROM data (combinational from address)
//   pix_valid      out  1          pixel available
//   pix_ready      in   1          consumer accepts pixel
//   pix_data       out  1          pixel value (1 = lit)
//   pix_row_last   out  1          last pixel of the current row
//   pix_frame_last out  1          last pixel of the frame
module hex_row_renderer #(
  parameter int NDIGITS = 4,
  parameter int GAP     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   value,
  output logic                   busy,
  output logic [3:0]             rom_digit,
  output logic [2:0]             rom_yoff,
  input  logic [4:0]             rom_bits,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_data,
  output logic                   pix_row_last,
  output logic                   pix_frame_last
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAPS} state_t;

  localparam logic [2:0] DIG_TOP  = 3'(NDIGITS - 1);
  localparam logic [2:0] GAP_LAST = 3'((GAP > 0) ? GAP - 1 : 0);

  state_t               state;
  logic [4*NDIGITS-1:0] val_q;
  logic [2:0]           row;
  logic [2:0]           digit;
  logic [2:0]           col;
  logic [2:0]           gap_cnt;
  logic [4:0]           shreg;
  logic [4:0]           load_bits;
  logic                 hs;

  assign hs = pix_valid & pix_ready;

  // Select one nibble of the latched value by digit index.
  function automatic logic [3:0] nibble(input logic [4*NDIGITS-1:0] v,
                                        input logic [2:0] d);
    logic [4*NDIGITS-1:0] s;
    s = v >> {d, 2'b00};
    return s[3:0];
  endfunction

`ifdef HEX_RENDER_LEADING_BLANK_EN
  logic [NDIGITS-1:0] blank_q;

  // Flag every nibble that belongs to the run of zeros starting at the MSB.
  // Digit 0 is excluded so that a zero value still shows a single "0".
  function automatic logic [NDIGITS-1:0] lead_zero(input logic [4*NDIGITS-1:0] v);
    logic [NDIGITS-1:0] m;
    logic               run;
    run = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      run  = run && (v[4*i +: 4] == 4'h0);
      m[i] = run;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  always_comb begin
    logic [NDIGITS-1:0] bs;
    bs        = blank_q >> digit;
    load_bits = bs[0] ? 5'd0 : rom_bits;
  end
`else
  assign load_bits = rom_bits;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      val_q          <= '0;
      row            <= '0;
      digit          <= '0;
      col            <= '0;
      gap_cnt        <= '0;
      shreg          <= '0;
      busy           <= 1'b0;
      rom_digit      <= '0;
      rom_yoff       <= '0;
      pix_valid      <= 1'b0;
      pix_data       <= 1'b0;
      pix_row_last   <= 1'b0;
      pix_frame_last <= 1'b0;
`ifdef HEX_RENDER_LEADING_BLANK_EN
      blank_q        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            val_q     <= value;
            row       <= '0;
            digit     <= DIG_TOP;
            col       <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b1;
            rom_digit <= value[4*NDIGITS-1 -: 4];
            rom_yoff  <= '0;
            state     <= LOAD;
`ifdef HEX_RENDER_LEADING_BLANK_EN
            blank_q   <= lead_zero(value);
`endif
          end
        end

        // ROM address was set on entry; capture the glyph row now.
        LOAD: begin
          shreg          <= load_bits;
          col            <= '0;
          pix_valid      <= 1'b1;
          pix_data       <= load_bits[0];
          pix_row_last   <= 1'b0;
          pix_frame_last <= 1'b0;
          state          <= SHIFT;
        end

        SHIFT: begin
          if (hs) begin
            shreg <= shreg >> 1;
            if (col != 3'd4) begin
              col            <= col + 3'd1;
              pix_data       <= shreg[1];
              // Flags are set when entering col 4 so they present with that pixel.
              pix_row_last   <= (col == 3'd3) && (digit == 3'd0);
              pix_frame_last <= (col == 3'd3) && (digit == 3'd0) && (row == 3'd4);
            end else begin
              col            <= '0;
              pix_data       <= 1'b0;
              pix_row_last   <= 1'b0;
              pix_frame_last <= 1'b0;
              if (digit != 3'd0) begin
                digit <= digit - 3'd1;
                if (GAP > 0) begin
                  gap_cnt   <= '0;
                  pix_valid <= 1'b1;
                  state     <= GAPS;
                end else begin
                  pix_valid <= 1'b0;
                  rom_digit <= nibble(val_q, digit - 3'd1);
                  rom_yoff  <= row;
                  state     <= LOAD;
                end
              end else if (row != 3'd4) begin
                row       <= row + 3'd1;
                digit     <= DIG_TOP;
                pix_valid <= 1'b0;
                rom_digit <= nibble(val_q, DIG_TOP);
                rom_yoff  <= row + 3'd1;
                state     <= LOAD;
              end else begin
                pix_valid <= 1'b0;
                busy      <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end

        // digit was already decremented on entry, so it names the next glyph.
        GAPS: begin
          if (hs) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt   <= '0;
              pix_valid <= 1'b0;
              rom_digit <= nibble(val_q, digit);
              rom_yoff  <= row;
              state     <= LOAD;
            end else begin
              gap_cnt <= gap_cnt + 3'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_row_renderer.sv
module tb_hex_row_renderer;

  localparam int ROWLEN = 23;
  localparam int FRAME  = 115;

`ifdef HEX_RENDER_LEADING_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic [3:0]  rom_digit;
  logic [2:0]  rom_yoff;
  logic [4:0]  rom_bits;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_data;
  logic        pix_row_last;
  logic        pix_frame_last;

  int errors = 0;
  int checks = 0;

  bit exp_d  [FRAME];
  bit exp_rl [FRAME];
  bit exp_fl [FRAME];

  always #5 clk = ~clk;

  hex_row_renderer #(.NDIGITS(4), .GAP(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .value          (value),
    .busy           (busy),
    .rom_digit      (rom_digit),
    .rom_yoff       (rom_yoff),
    .rom_bits       (rom_bits),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .pix_row_last   (pix_row_last),
    .pix_frame_last (pix_frame_last)
  );

  // Stand-in glyph ROM: asymmetric rows so bit order mistakes are visible.
  function automatic logic [4:0] glyph(input logic [3:0] d, input logic [2:0] y);
    return 5'(int'(d) * 7 + int'(y) * 5 + 3);
  endfunction

  assign rom_bits = glyph(rom_digit, rom_yoff);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pixel stream: rows 0..4, digits 3..0, glyph bits LSB-first,
  // one blank column after every digit except the last.
  task automatic build(input logic [15:0] v);
    int   idx;
    bit   lead;
    bit   blank;
    logic [3:0] nib;
    logic [4:0] g;
    idx = 0;
    for (int r = 0; r < 5; r++) begin
      lead = 1'b1;
      for (int d = 3; d >= 0; d--) begin
        nib   = v[4*d +: 4];
        lead  = lead && (nib == 4'h0);
        blank = BLANK_EN && lead && (d != 0);
        g     = glyph(nib, 3'(r));
        for (int c = 0; c < 5; c++) begin
          exp_d[idx]  = blank ? 1'b0 : g[c];
          exp_rl[idx] = (d == 0) && (c == 4);
          exp_fl[idx] = (d == 0) && (c == 4) && (r == 4);
          idx++;
        end
        if (d > 0) begin
          exp_d[idx]  = 1'b0;
          exp_rl[idx] = 1'b0;
          exp_fl[idx] = 1'b0;
          idx++;
        end
      end
    end
  endtask

  // Called at a negedge with the DUT idle; leaves at the negedge right after
  // the final handshake (or after recovery from an injected reset).
  task automatic run_frame(input logic [15:0] v, input int stall_at, input int stall_len,
                           input int inject_at, input int abort_at, input bit alt_ready);
    int px, li, cyc, stall_left;
    bit injected, aborted, stalling;
    build(v);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value = 16'h5555;
    px = 0; li = 0; cyc = 0; stall_left = stall_len;
    injected = 1'b0; aborted = 1'b0;
    while (px < FRAME && cyc < 1000) begin
      if (abort_at >= 0 && px == abort_at) begin
        aborted = 1'b1;
        break;
      end
      start = 1'b0;
      if (busy && !pix_valid) begin
        check("rom_digit", rom_digit, v[4*(3 - li % 4) +: 4]);
        check("rom_yoff", rom_yoff, li / 4);
        li++;
      end
      stalling  = (stall_left > 0) && (px == stall_at) && pix_valid;
      pix_ready = alt_ready ? cyc[0] : 1'b1;
      if (stalling) begin
        pix_ready = 1'b0;
        stall_left--;
        check("stall_valid", pix_valid, 1'b1);
      end
      if (inject_at >= 0 && px == inject_at && !injected) begin
        start    = 1'b1;
        value    = 16'hFFFF;
        injected = 1'b1;
      end
      if (pix_valid) begin
        check($sformatf("data_px%0d", px), pix_data, exp_d[px]);
        check($sformatf("row_last_px%0d", px), pix_row_last, exp_rl[px]);
        check($sformatf("frame_last_px%0d", px), pix_frame_last, exp_fl[px]);
        if (pix_ready) px++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_valid", pix_valid, 1'b0);
      check("abort_data", pix_data, 1'b0);
      check("abort_row_last", pix_row_last, 1'b0);
      check("abort_frame_last", pix_frame_last, 1'b0);
      check("abort_rom_digit", rom_digit, 4'h0);
      check("abort_rom_yoff", rom_yoff, 3'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("post_abort_busy", busy, 1'b0);
        check("post_abort_valid", pix_valid, 1'b0);
      end
    end else begin
      check("handshakes", px, FRAME);
      check("loads", li, 20);
      check("busy_after", busy, 1'b0);
      check("valid_after", pix_valid, 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    value     = 16'h0000;
    pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", pix_valid, 1'b0);
    check("rst_data", pix_data, 1'b0);
    check("rst_row_last", pix_row_last, 1'b0);
    check("rst_frame_last", pix_frame_last, 1'b0);
    check("rst_rom_digit", rom_digit, 4'h0);
    check("rst_rom_yoff", rom_yoff, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // All-zero value, free-running consumer.
    run_frame(16'h0000, -1, 0, -1, -1, 1'b0);
    // Mixed digits; started in the cycle busy drops.
    run_frame(16'h1A3F, -1, 0, -1, -1, 1'b0);
    // Three-cycle stall on pixel 7.
    run_frame(16'h1A3F, 7, 3, -1, -1, 1'b0);
    // Start with a different value mid-frame must be ignored.
    run_frame(16'h1A3F, -1, 0, 50, -1, 1'b0);
    // Leading zeros with an alternating consumer.
    run_frame(16'h00A3, -1, 0, -1, -1, 1'b1);
    // Reset in the middle of a frame.
    run_frame(16'h1A3F, -1, 0, -1, 40, 1'b0);
    // Fresh frame after the abort.
    run_frame(16'h7B2C, -1, 0, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
